// File: rtl/reg_writeback.sv
// ---------------------------------------------------------------------------
// reg_writeback
//
// Write-back arbiter for the single register-file write port. Two result
// sources share the port:
//   - in-order pipeline results from the WB stage (always win, no backpressure)
//   - out-of-order long-latency results (mul/div, load miss), buffered in a
//     small FIFO and drained whenever the pipeline leaves the port idle.
// A 32-entry busy scoreboard marks registers with a long-latency result still
// outstanding so decode can stall on RAW (q_busy*) and WAW (iss_busy) hazards.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   wb_en/wb_rd/wb_data   pipeline write-back result
//   lu_valid/lu_ready     long-latency result handshake (lu_ready = !full)
//   lu_rd/lu_data         long-latency destination and value
//   iss_valid/iss_rd      decode issues a long-latency op -> mark rd busy
//   q_addr1/q_addr2       decode source-register queries
//   q_busy1/q_busy2       queried register has a pending long-latency write
//   iss_busy              iss_rd already has a pending long-latency write
//   rf_we/rf_waddr/rf_wdata  registered register-file write port
// ---------------------------------------------------------------------------
module reg_writeback #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  q_addr1,
  input  logic [4:0]  q_addr2,
  output logic        q_busy1,
  output logic        q_busy2,
  output logic        iss_busy,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int AW = $clog2(DEPTH);

  // FIFO storage and pointers. Pointers carry one extra wrap bit so that
  // full and empty can be told apart without a separate count.
  logic [4:0]  mem_rd   [DEPTH];
  logic [31:0] mem_data [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;

  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        wb_sel;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  logic [31:0] busy;
  logic [31:0] busy_next;

  // Status comes from registered pointers only, so an entry written this
  // cycle is not visible to the pop logic until the next cycle, and a pop
  // in a full cycle does not open a slot until the next cycle.
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);

  assign lu_ready = !full;

  // Writes to x0 are architecturally void; dropping them here keeps them
  // out of both the FIFO and the write port.
  assign push   = lu_valid && lu_ready && (lu_rd != 5'd0);
  assign wb_sel = wb_en && (wb_rd != 5'd0);
  assign pop    = !wb_sel && !empty;

  assign head_rd   = mem_rd[rptr[AW-1:0]];
  assign head_data = mem_data[rptr[AW-1:0]];

  // FIFO data array: no reset needed, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wptr[AW-1:0]]   <= lu_rd;
      mem_data[wptr[AW-1:0]] <= lu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Scoreboard update. The set is applied after the clear so that a
  // re-issue to the register being drained keeps it busy.
  always_comb begin
    busy_next = busy;
    if (pop) busy_next[head_rd] = 1'b0;
    if (iss_valid && (iss_rd != 5'd0)) busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Bit 0 is never set, so x0 queries read 0 without extra decode.
  assign q_busy1  = busy[q_addr1];
  assign q_busy2  = busy[q_addr2];
  assign iss_busy = busy[iss_rd];

  // Registered write port. Address and data hold when idle so the register
  // file sees stable inputs; only the enable drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'd0;
    end else if (wb_sel) begin
      rf_we    <= 1'b1;
      rf_waddr <= wb_rd;
      rf_wdata <= wb_data;
    end else if (pop) begin
      rf_we    <= 1'b1;
      rf_waddr <= head_rd;
      rf_wdata <= head_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;

  logic        clk;
  logic        rst;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  q_addr1;
  logic [4:0]  q_addr2;
  logic        q_busy1;
  logic        q_busy2;
  logic        iss_busy;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int checks = 0;
  int errors = 0;

  reg_writeback #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .q_addr1(q_addr1), .q_addr2(q_addr2),
    .q_busy1(q_busy1), .q_busy2(q_busy2), .iss_busy(iss_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per cycle: inputs, then combinational outputs expected before
  // the posedge, then the write port expected after it.
  typedef struct {
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  qa1;
    logic [4:0]  qa2;
    logic        ex_rdy;
    logic        ex_qb1;
    logic        ex_qb2;
    logic        ex_ib;
    logic        ex_we;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
  } vec_t;

  localparam int NV = 37;
  vec_t vecs[NV];

  function automatic vec_t mk(
    input logic we_i, input logic [4:0] wrd, input logic [31:0] wd,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
    input logic iv, input logic [4:0] ird,
    input logic [4:0] a1, input logic [4:0] a2,
    input logic rdy, input logic b1, input logic b2, input logic ib,
    input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd);
    vec_t v;
    v.wb_en = we_i; v.wb_rd = wrd; v.wb_data = wd;
    v.lu_valid = lv; v.lu_rd = lrd; v.lu_data = ld;
    v.iss_valid = iv; v.iss_rd = ird; v.qa1 = a1; v.qa2 = a2;
    v.ex_rdy = rdy; v.ex_qb1 = b1; v.ex_qb2 = b2; v.ex_ib = ib;
    v.ex_we = ewe; v.ex_waddr = ewa; v.ex_wdata = ewd;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic drive_idle();
    wb_en = 0; wb_rd = 0; wb_data = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
    iss_valid = 0; iss_rd = 0; q_addr1 = 0; q_addr2 = 0;
  endtask

  initial begin
    // scoreboard: issue x9, query, enqueue, drain
    vecs[0]  = mk(0,0,0,          0,0,0,            1,9, 9,0, 1,0,0,0, 0,0,0);
    vecs[1]  = mk(0,0,0,          0,0,0,            0,9, 9,0, 1,1,0,1, 0,0,0);
    vecs[2]  = mk(0,0,0,          1,9,32'hDEAD0009, 0,0, 9,0, 1,1,0,0, 0,0,0);
    vecs[3]  = mk(0,0,0,          0,0,0,            0,0, 9,0, 1,1,0,0, 1,9,32'hDEAD0009);
    vecs[4]  = mk(0,0,0,          0,0,0,            0,0, 9,0, 1,0,0,0, 0,0,0);
    // re-issue x9 in the drain cycle: set beats clear
    vecs[5]  = mk(0,0,0,          0,0,0,            1,9, 9,0, 1,0,0,0, 0,0,0);
    vecs[6]  = mk(0,0,0,          1,9,32'h99,       0,0, 9,0, 1,1,0,0, 0,0,0);
    vecs[7]  = mk(0,0,0,          0,0,0,            1,9, 9,0, 1,1,0,1, 1,9,32'h99);
    vecs[8]  = mk(0,0,0,          0,0,0,            0,9, 9,0, 1,1,0,1, 0,0,0);
    // x0 filter
    vecs[9]  = mk(1,0,32'h456,    1,0,32'h123,      1,0, 0,0, 1,0,0,0, 0,0,0);
    vecs[10] = mk(0,0,0,          0,0,0,            0,0, 0,0, 1,0,0,0, 0,0,0);
    // pipeline priority over a queued x7
    vecs[11] = mk(0,0,0,          1,7,32'h77,       1,7, 0,7, 1,0,0,0, 0,0,0);
    vecs[12] = mk(1,5,32'hAAAA0005, 0,0,0,          0,0, 0,7, 1,0,1,0, 1,5,32'hAAAA0005);
    vecs[13] = mk(0,0,0,          0,0,0,            0,0, 0,7, 1,0,1,0, 1,7,32'h77);
    vecs[14] = mk(0,0,0,          0,0,0,            0,0, 0,7, 1,0,0,0, 0,0,0);
    // fill to full while the pipeline holds the port
    for (int k = 0; k < 4; k++)
      vecs[15+k] = mk(1,20,32'h14+k, 1,5'(1+k),32'h101+k, 0,0, 0,0, 1,0,0,0, 1,20,32'h14+k);
    vecs[19] = mk(1,20,32'h18,    1,5,32'h105,      0,0, 0,0, 0,0,0,0, 1,20,32'h18);
    // first pop while full: still not ready; ready returns the next cycle
    vecs[20] = mk(0,0,0,          1,5,32'h105,      0,0, 0,0, 0,0,0,0, 1,1,32'h101);
    vecs[21] = mk(0,0,0,          1,5,32'h105,      0,0, 0,0, 1,0,0,0, 1,2,32'h102);
    vecs[22] = mk(0,0,0,          0,0,0,            0,0, 0,0, 1,0,0,0, 1,3,32'h103);
    vecs[23] = mk(0,0,0,          0,0,0,            0,0, 0,0, 1,0,0,0, 1,4,32'h104);
    vecs[24] = mk(0,0,0,          0,0,0,            0,0, 0,0, 1,0,0,0, 1,5,32'h105);
    vecs[25] = mk(0,0,0,          0,0,0,            0,0, 0,0, 1,0,0,0, 0,0,0);
    // pointer wrap: 10 streaming enqueue/dequeue pairs
    for (int i = 0; i < 10; i++)
      vecs[26+i] = mk(0,0,0, 1,5'(10+i),32'(i*'h11), 0,0, 0,0, 1,0,0,0,
                      (i > 0), 5'(9+i), 32'((i-1)*'h11));
    vecs[36] = mk(0,0,0,          0,0,0,            0,0, 0,0, 1,0,0,0, 1,19,32'h99);

    drive_idle();
    rst = 1'b1;
    #1;
    check("reset rf_we", 0, 32'(rf_we), 0);
    check("reset rf_waddr", 0, 32'(rf_waddr), 0);
    check("reset rf_wdata", 0, rf_wdata, 0);
    check("reset lu_ready", 0, 32'(lu_ready), 1);
    check("reset q_busy1", 0, 32'(q_busy1), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < NV; n++) begin
      @(negedge clk);
      wb_en = vecs[n].wb_en; wb_rd = vecs[n].wb_rd; wb_data = vecs[n].wb_data;
      lu_valid = vecs[n].lu_valid; lu_rd = vecs[n].lu_rd; lu_data = vecs[n].lu_data;
      iss_valid = vecs[n].iss_valid; iss_rd = vecs[n].iss_rd;
      q_addr1 = vecs[n].qa1; q_addr2 = vecs[n].qa2;
      #1;
      check("lu_ready", n, 32'(lu_ready), 32'(vecs[n].ex_rdy));
      check("q_busy1", n, 32'(q_busy1), 32'(vecs[n].ex_qb1));
      check("q_busy2", n, 32'(q_busy2), 32'(vecs[n].ex_qb2));
      check("iss_busy", n, 32'(iss_busy), 32'(vecs[n].ex_ib));
      @(posedge clk);
      #1;
      check("rf_we", n, 32'(rf_we), 32'(vecs[n].ex_we));
      if (vecs[n].ex_we) begin
        check("rf_waddr", n, 32'(rf_waddr), 32'(vecs[n].ex_waddr));
        check("rf_wdata", n, rf_wdata, vecs[n].ex_wdata);
      end
    end

    // Reset mid-traffic: queue x21..x23 (marked busy) behind a busy pipeline.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_idle();
      wb_en = 1; wb_rd = 20; wb_data = 32'h500 + k;
      lu_valid = 1; lu_rd = 5'(21 + k); lu_data = 32'h2100 + k;
      iss_valid = 1; iss_rd = 5'(21 + k);
    end
    @(negedge clk);
    drive_idle();
    wb_en = 1; wb_rd = 20; wb_data = 32'h600;
    q_addr1 = 21; q_addr2 = 22; iss_rd = 23;
    #1;
    check("pre-reset q_busy1", 100, 32'(q_busy1), 1);
    check("pre-reset rf_we", 100, 32'(rf_we), 1);
    #1;
    rst = 1'b1;
    #1;
    check("mid-reset rf_we", 101, 32'(rf_we), 0);
    check("mid-reset lu_ready", 101, 32'(lu_ready), 1);
    check("mid-reset q_busy1", 101, 32'(q_busy1), 0);
    check("mid-reset q_busy2", 101, 32'(q_busy2), 0);
    check("mid-reset iss_busy", 101, 32'(iss_busy), 0);
    @(negedge clk);
    rst = 1'b0;
    wb_en = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("post-reset rf_we", 102 + k, 32'(rf_we), 0);
      check("post-reset q_busy1", 102 + k, 32'(q_busy1), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
